// File: rtl/ooo_pipe_pkg.sv
// Shared constants and types for the out-of-order core pipeline stages.
package ooo_pipe_pkg;

  localparam int PIPE_W = 151;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/en_reg_bank.sv
// WIDTH-bit payload register with load enable and asynchronous active-low clear.
module en_reg_bank
  import ooo_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Payload storage: cleared by reset, loaded only when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline stage (main + skid) with fully registered outputs
// and synchronous flush; handshake outputs decode only the occupancy state.
module pipe_skid_stage
  import ooo_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_r;
  skid_state_t      fsm_nxt_s;
  skid_state_t      state_nxt_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             main_load_s;
  logic             skid_load_s;
  logic             main_from_skid_s;
  logic             main_en_s;
  logic             skid_en_s;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] skid_q_s;

  assign in_ready   = (state_r != FULL);
  assign out_valid  = (state_r != EMPTY);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Occupancy next-state and data-load decisions.
  always_comb begin
    fsm_nxt_s        = state_r;
    main_load_s      = 1'b0;
    skid_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          fsm_nxt_s   = ONE;
          main_load_s = 1'b1;
        end else begin
          fsm_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s && out_fire_s) begin
          fsm_nxt_s   = ONE;
          main_load_s = 1'b1;
        end else if (in_fire_s) begin
          fsm_nxt_s   = FULL;
          skid_load_s = 1'b1;
        end else if (out_fire_s) begin
          fsm_nxt_s = EMPTY;
        end else begin
          fsm_nxt_s = ONE;
        end
      end
      FULL: begin
        if (out_fire_s) begin
          fsm_nxt_s        = ONE;
          main_load_s      = 1'b1;
          main_from_skid_s = 1'b1;
        end else begin
          fsm_nxt_s = FULL;
        end
      end
      default: begin
        fsm_nxt_s = EMPTY;
      end
    endcase
  end

  // Flush kills all entries; suppressing the loads keeps a dropped payload out of main.
  assign state_nxt_s = flush ? EMPTY : fsm_nxt_s;
  assign main_en_s   = main_load_s & ~flush;
  assign skid_en_s   = skid_load_s & ~flush;
  assign main_d_s    = main_from_skid_s ? skid_q_s : in_data;

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  en_reg_bank #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en_s),
    .d     (main_d_s),
    .q     (out_data)
  );

  en_reg_bank #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en_s),
    .d     (in_data),
    .q     (skid_q_s)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a depth-2 FIFO model checked every cycle, plus
// directed scenarios with literal expectations and a long randomized run.
module tb_pipe_skid_stage;

  localparam int W = 151;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_q[$];

  pipe_skid_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO holding at most two payloads.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else begin
      automatic bit can_in  = in_valid && (model_q.size() < 2);
      automatic bit can_out = out_ready && (model_q.size() > 0);
      if (can_out) void'(model_q.pop_front());
      if (can_in) model_q.push_back(in_data);
      if (flush) model_q.delete();
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("model_out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, (model_q.size() > 0)});
      check("model_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, (model_q.size() < 2)});
      if (model_q.size() > 0) check("model_out_data", out_data, model_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic check_io(input string name, input logic v, input logic r, input logic [W-1:0] d, input bit chk_d);
    check({name, "_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, v});
    check({name, "_ready"}, {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, r});
    if (chk_d) check({name, "_data"}, out_data, d);
  endtask

  task automatic async_reset_check(input string name);
    reset = 1'b0;
    #1;
    check_io(name, 1'b0, 1'b1, '0, 1'b1);
  endtask

  logic [159:0] rnd;

  initial begin
    // Power-on reset.
    #1;
    async_reset_check("por");
    tick();
    tick();
    reset = 1'b1;

    // Mid-stream reset from FULL, then first accept after release.
    drive(1'b1, 151'h71, 1'b0, 1'b0); tick();
    drive(1'b1, 151'h72, 1'b0, 1'b0); tick();
    check_io("full_before_rst", 1'b1, 1'b0, 151'h71, 1'b1);
    #1;
    async_reset_check("mid_rst");
    tick();
    reset = 1'b1;
    drive(1'b1, 151'h1F, 1'b0, 1'b0); tick();
    check_io("post_rst_accept", 1'b1, 1'b1, 151'h1F, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_io("post_rst_drain", 1'b0, 1'b1, '0, 1'b0);

    // Streaming at full rate.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, W'(k), 1'b1, 1'b0); tick();
      check_io("stream", 1'b1, 1'b1, W'(k), 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_io("stream_end", 1'b0, 1'b1, '0, 1'b0);

    // Backpressure.
    drive(1'b1, 151'hA, 1'b0, 1'b0); tick();
    check_io("bp_one", 1'b1, 1'b1, 151'hA, 1'b1);
    drive(1'b1, 151'hB, 1'b0, 1'b0); tick();
    check_io("bp_full", 1'b1, 1'b0, 151'hA, 1'b1);
    drive(1'b1, 151'hC, 1'b0, 1'b0); tick();
    check_io("bp_hold", 1'b1, 1'b0, 151'hA, 1'b1);
    drive(1'b1, 151'hC, 1'b1, 1'b0); tick();
    check_io("bp_drain1", 1'b1, 1'b1, 151'hB, 1'b1);
    drive(1'b1, 151'hC, 1'b1, 1'b0); tick();
    check_io("bp_drain2", 1'b1, 1'b1, 151'hC, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_io("bp_empty", 1'b0, 1'b1, '0, 1'b0);

    // Flush from FULL with a payload offered.
    drive(1'b1, 151'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 151'h22, 1'b0, 1'b0); tick();
    drive(1'b1, 151'h33, 1'b1, 1'b1); tick();
    check_io("flush_full", 1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_io("flush_full_after", 1'b0, 1'b1, '0, 1'b0);

    // Flush in ONE while an accept fires: dropped payload never appears.
    drive(1'b1, 151'h44, 1'b0, 1'b0); tick();
    drive(1'b1, 151'h55, 1'b0, 1'b1); tick();
    check_io("flush_one", 1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 151'h66, 1'b0, 1'b0); tick();
    check_io("after_flush_accept", 1'b1, 1'b1, 151'h66, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0); tick();

    // Simultaneous accept and consume in ONE.
    drive(1'b1, 151'h5, 1'b0, 1'b0); tick();
    check_io("sim_one", 1'b1, 1'b1, 151'h5, 1'b1);
    drive(1'b1, 151'h6, 1'b1, 1'b0); tick();
    check_io("sim_swap", 1'b1, 1'b1, 151'h6, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check_io("sim_empty", 1'b0, 1'b1, '0, 1'b0);

    // Randomized valid/ready/flush with an occasional asynchronous reset.
    for (int c = 0; c < 12000; c++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), rnd[W-1:0], ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0));
      if (c == 6000) begin
        #1;
        async_reset_check("rand_rst");
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();
    check_io("final_empty", 1'b0, 1'b1, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Elastic pipeline register stage for the out-of-order core: accepts a WIDTH-bit payload from an upstream producer under a valid/ready handshake and presents it, fully registered, to a downstream consumer. Two internal entries (main + skid) sustain one transfer per cycle with no combinational path from `out_ready` to `in_ready`. A synchronous `flush` discards everything in flight on branch mispredict or exception. It sits between enabled-register pipeline boundaries such as dispatch → issue and issue → execute.

## Interface
- WIDTH, 151, payload width in bits (one micro-op bundle)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  downstream payload valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  downstream payload (main entry)

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Occupancy FSM, state register only (no data-dependent state):
  - EMPTY: out_valid=0, in_ready=1. in_fire → ONE, main ← in_data.
  - ONE: out_valid=1, in_ready=1. in_fire & out_fire → ONE, main ← in_data. in_fire only → FULL, skid ← in_data. out_fire only → EMPTY. Neither → ONE, hold.
  - FULL: out_valid=1, in_ready=0. out_fire → ONE, main ← skid. Else hold.
- flush=1 at a rising edge: next state EMPTY, regardless of in_valid/out_ready; a payload presented with in_fire that cycle is dropped; an out_fire that cycle still counts as completed downstream.
- Data registers load only on the listed events; otherwise hold (enable-gated). out_data is undefined-but-stable content when out_valid=0; the bench must not check it.
- Ordering strictly FIFO; no payload is duplicated or lost except by flush.
- out_data changes only on an edge where out_fire occurred or state was EMPTY.

## Timing
- Reset (reset=0, asynchronous): state EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0. Release is sampled synchronously; first accept possible on the first edge with reset=1.
- Latency: in_fire at edge N → out_valid=1 with that payload after edge N (visible cycle N+1).
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- in_ready and out_valid are pure functions of the state register; no combinational input → output paths.
- in_ready falls the cycle after the second unconsumed accept; returns 1 the cycle after the out_fire that drains FULL.
- Reset mid-operation: all entries discarded immediately, outputs at reset values within the same cycle.
- flush and reset both asserted: reset dominates.

## Structure
- Package `ooo_pipe_pkg`: `PIPE_W = 151` constant; `skid_state_t` enum {EMPTY, ONE, FULL} (2 bits).
- One sub-module: `en_reg_bank` — WIDTH-bit register with enable and async active-low clear; instantiated twice (main, skid). FSM and mux live in the top.

## Test plan
- Reset: drive reset=0 mid-stream with FULL state → out_valid=0, in_ready=1, out_data=0 immediately; after release, in_data=0x1F accepted → out_data=0x1F one cycle later.
- Streaming: out_ready=1, send 0x01..0x08 back-to-back → out_data 0x01..0x08 on consecutive cycles, in_ready never falls.
- Backpressure: out_ready=0, send 0xA, 0xB → in_ready=0 after second accept, 0xC held off; raise out_ready → outputs 0xA, 0xB, 0xC in order, in_ready returns 1 the cycle after 0xA leaves.
- Flush: FULL with 0x11, 0x22, flush=1 with in_valid=1, in_data=0x33 → next cycle EMPTY, out_valid=0; 0x33 never appears.
- Simultaneous in/out in ONE: main=0x5, in 0x6 with out_ready=1 → 0x5 consumed, out_data=0x6 next cycle, state stays ONE.
- Random valid/ready (≥10k cycles, WIDTH=151) against scoreboard FIFO → exact order, no loss, no duplication.
